gate_delay_tester: RTL and testbench
====================================

Name: gate_delay_tester

Overview:
- Self-sequencing characterisation controller for a single combinational gate under test (DUT): 1-, 2- or 3-input primitives with asymmetric rise/fall delays.
- On `start`, it walks the DUT inputs through a full Gray-code cycle and counts clock cycles from each input change to the resulting output change.
- Reports maximum rise delay, maximum fall delay, transition counts, and glitch/static status.
- Sits between the gate library and the gate-level testbenches; one tester instance per DUT.

Parameters:
- N_IN, 2, DUT input count (1..3); steps per run = 2^N_IN.
- CNT_W, 8, width of delay counters and result fields.
- TIMEOUT, 32, cycles waited for an output change before the step is declared static; must be < 2^CNT_W-1.
- SETTLE_CYC, 4, hold cycles after the baseline vector and after each detected transition.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; honoured only in IDLE.
- abort  input  1  returns to IDLE from any state; results invalid.
- dut_in  output  N_IN  registered stimulus to the DUT.
- dut_out  input  1  DUT output, sampled at each rising edge.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse at end of run.
- valid  output  1  results valid; set with done, cleared by start/abort/reset.
- max_rise  output  CNT_W  largest 0->1 delay in cycles.
- max_fall  output  CNT_W  largest 1->0 delay in cycles.
- rise_cnt  output  3  number of 0->1 transitions observed.
- fall_cnt  output  3  number of 1->0 transitions observed.
- static_cnt  output  4  steps that hit TIMEOUT.
- glitch  output  1  sticky: output changed again during a settle hold.

Behaviour:
- Reset: dut_in=0, busy=0, done=0, valid=0. All results and counters 0. State IDLE.
- Reset takes effect immediately (async) mid-run; no done pulse.
- States: IDLE, BASE, APPLY, WAIT, HOLD, DONE.
- IDLE:
  - start=1 clears results and valid, sets dut_in=gray(0)=0, step=0, and moves to BASE.
  - start is ignored while busy.
- BASE:
  - Holds SETTLE_CYC cycles.
  - On the last cycle, latches the sampled dut_out into prev, then moves to APPLY.
- APPLY (1 cycle):
  - step++.
  - dut_in <= gray(step mod 2^N_IN), where gray(k)=k^(k>>1).
  - cnt <= 0. Moves to WAIT.
  - Step 2^N_IN restores vector 0 (wrap transition).
- WAIT, evaluated each cycle:
  - cnt++ (saturating at 2^CNT_W-1).
  - If dut_out != prev, the delay is cnt+1: the first edge after the dut_in update counts as 1.
  - On a change:
    - 0->1 updates max_rise=max(max_rise,delay) and rise_cnt++.
    - 1->0 updates max_fall and fall_cnt++.
    - prev <= dut_out, then go to HOLD.
  - If delay reaches TIMEOUT with no change: static_cnt++, then go to HOLD.
- HOLD:
  - Lasts SETTLE_CYC cycles.
  - Any dut_out != prev sets glitch=1 and updates prev.
  - Afterwards: if step == 2^N_IN go to DONE, else APPLY.
- DONE (1 cycle):
  - done=1, valid=1, busy=0. Then IDLE.
  - Results and dut_in hold until the next start.
- abort:
  - Any state goes to IDLE next edge; dut_in=0, valid=0, no done.
  - abort has priority over start in the same cycle.
- Simultaneous change and timeout in the same cycle: the change wins.

Test Plan:
All scenarios use a 3 ns clock and the library gate models.
1. NAND (N_IN=2), `#(10,8)`:
   - Sequence 00,01,11,10,00 gives outputs 1,1,0,1,1.
   - Expect rise_cnt=1, fall_cnt=1, static_cnt=2, max_rise=4, max_fall=3, glitch=0, one done pulse, valid=1.
2. NOR (N_IN=2), `#(10,14)`:
   - Expect rise_cnt=1, fall_cnt=1, static_cnt=2, max_rise=4, max_fall=5.
3. Inverter (N_IN=1), `#(5,7)`:
   - Vectors 0,1,0.
   - Expect fall_cnt=1 with max_fall=3, rise_cnt=1 with max_rise=2, static_cnt=0.
4. dut_out tied 0, TIMEOUT=32:
   - Expect static_cnt=4 and max_rise=max_fall=0.
   - Each WAIT lasts exactly 32 cycles; done still pulses once.
5. Behavioural DUT that pulses its output 1 cycle high, 2 cycles after the change:
   - Expect glitch=1, and the rise is counted once.
6. Interrupt cases:
   - abort asserted in the third WAIT: expect IDLE next cycle, dut_in=0, valid=0, no done.
   - rst_n low for half a cycle mid-run: all outputs 0 immediately.
   - start pulsed during busy is ignored.

Source files
------------

// File: rtl/gate_delay_tester.sv
// Characterisation controller for one combinational gate: walks its inputs through a
// Gray-code cycle and measures the per-edge output delay in clock cycles.
`timescale 1ns/100ps
module gate_delay_tester #(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [CNT_W-1:0] max_rise,
  output logic [CNT_W-1:0] max_fall,
  output logic [2:0]       rise_cnt,
  output logic [2:0]       fall_cnt,
  output logic [3:0]       static_cnt,
  output logic             glitch
);

  localparam int unsigned STEP_W = N_IN + 1;
  localparam int unsigned HOLD_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(1 << N_IN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_APPLY,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [STEP_W-1:0]  step, step_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               prev, prev_d;

  logic [N_IN-1:0]    dut_in_d;
  logic               busy_d, done_d, valid_d, glitch_d;
  logic [CNT_W-1:0]   max_rise_d, max_fall_d;
  logic [2:0]         rise_cnt_d, fall_cnt_d;
  logic [3:0]         static_cnt_d;

  logic [CNT_W-1:0]   delay;
  logic [STEP_W-1:0]  step_inc;
  logic [N_IN-1:0]    gray_idx;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= '0;
      cnt        <= '0;
      hold_cnt   <= '0;
      prev       <= 1'b0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      glitch     <= 1'b0;
      max_rise   <= '0;
      max_fall   <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      static_cnt <= '0;
    end else begin
      state      <= state_d;
      step       <= step_d;
      cnt        <= cnt_d;
      hold_cnt   <= hold_d;
      prev       <= prev_d;
      dut_in     <= dut_in_d;
      busy       <= busy_d;
      done       <= done_d;
      valid      <= valid_d;
      glitch     <= glitch_d;
      max_rise   <= max_rise_d;
      max_fall   <= max_fall_d;
      rise_cnt   <= rise_cnt_d;
      fall_cnt   <= fall_cnt_d;
      static_cnt <= static_cnt_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d      = state;
    step_d       = step;
    cnt_d        = cnt;
    hold_d       = hold_cnt;
    prev_d       = prev;
    dut_in_d     = dut_in;
    valid_d      = valid;
    glitch_d     = glitch;
    max_rise_d   = max_rise;
    max_fall_d   = max_fall;
    rise_cnt_d   = rise_cnt;
    fall_cnt_d   = fall_cnt;
    static_cnt_d = static_cnt;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    // The first edge after the stimulus update counts as a delay of 1
    delay    = cnt + CNT_W'(1);
    step_inc = step + STEP_W'(1);
    gray_idx = step_inc[N_IN-1:0];

    unique case (state)
      S_IDLE: begin
        if (start) begin
          valid_d      = 1'b0;
          glitch_d     = 1'b0;
          max_rise_d   = '0;
          max_fall_d   = '0;
          rise_cnt_d   = '0;
          fall_cnt_d   = '0;
          static_cnt_d = '0;
          dut_in_d     = '0;
          step_d       = '0;
          hold_d       = '0;
          state_d      = S_BASE;
        end
      end

      S_BASE: begin
        hold_d = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          prev_d  = dut_out;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        step_d   = step_inc;
        dut_in_d = gray_idx ^ (gray_idx >> 1);
        cnt_d    = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_W'(1);
        end
        // A change in the same cycle as the timeout still counts as a transition
        if (dut_out != prev) begin
          if (dut_out) begin
            if (delay > max_rise) max_rise_d = delay;
            rise_cnt_d = rise_cnt + 3'd1;
          end else begin
            if (delay > max_fall) max_fall_d = delay;
            fall_cnt_d = fall_cnt + 3'd1;
          end
          prev_d  = dut_out;
          hold_d  = '0;
          state_d = S_HOLD;
        end else if (delay >= TIMEOUT_C) begin
          static_cnt_d = static_cnt + 4'd1;
          hold_d       = '0;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        hold_d = hold_cnt + HOLD_W'(1);
        if (dut_out != prev) begin
          glitch_d = 1'b1;
          prev_d   = dut_out;
        end
        if (hold_cnt == HOLD_LAST) begin
          state_d = (step == LAST_STEP) ? S_DONE : S_APPLY;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      dut_in_d = '0;
      valid_d  = 1'b0;
    end

    // Flags are registered alongside the state they describe
    if (state_d == S_DONE) begin
      valid_d = 1'b1;
      done_d  = 1'b1;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

endmodule

// File: tb/tb_gate_delay_tester.sv
// Directed bench for gate_delay_tester: behavioural gate models with ns delays on a
// 3 ns clock, a table of full-run expectations, plus abort/reset/start corner cases.
`timescale 1ns/100ps
module tb_gate_delay_tester;

  localparam int M_NAND  = 0;
  localparam int M_NOR   = 1;
  localparam int M_TIED0 = 2;
  localparam int M_PULSE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #1.5 clk = ~clk;

  // Two-input instance
  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [1:0] dut_in2;
  logic       out2 = 1'b0;
  logic       busy2, done2, valid2, glitch2;
  logic [7:0] max_rise2, max_fall2;
  logic [2:0] rise_cnt2, fall_cnt2;
  logic [3:0] static_cnt2;

  // One-input instance
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [0:0] dut_in1;
  logic       out1 = 1'b0;
  logic       busy1, done1, valid1, glitch1;
  logic [7:0] max_rise1, max_fall1;
  logic [2:0] rise_cnt1, fall_cnt1;
  logic [3:0] static_cnt1;

  gate_delay_tester #(.N_IN(2), .CNT_W(8), .TIMEOUT(32), .SETTLE_CYC(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_in(dut_in2), .dut_out(out2), .busy(busy2), .done(done2), .valid(valid2),
    .max_rise(max_rise2), .max_fall(max_fall2), .rise_cnt(rise_cnt2),
    .fall_cnt(fall_cnt2), .static_cnt(static_cnt2), .glitch(glitch2)
  );

  gate_delay_tester #(.N_IN(1), .CNT_W(8), .TIMEOUT(32), .SETTLE_CYC(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_in(dut_in1), .dut_out(out1), .busy(busy1), .done(done1), .valid(valid1),
    .max_rise(max_rise1), .max_fall(max_fall1), .rise_cnt(rise_cnt1),
    .fall_cnt(fall_cnt1), .static_cnt(static_cnt1), .glitch(glitch1)
  );

  // Two-input gate model; kick2 forces re-evaluation after a mode switch
  int   mode2 = M_NAND;
  int   rise2 = 10, fall2 = 8;
  int   kick2 = 0;
  logic nv2;
  always begin
    @(dut_in2 or mode2 or kick2);
    if (mode2 == M_PULSE) begin
      if (dut_in2 == 2'b01) begin
        #7 out2 = 1'b1;
        #3 out2 = 1'b0;
      end else begin
        out2 = 1'b0;
      end
    end else begin
      case (mode2)
        M_NAND:  nv2 = ~(dut_in2[1] & dut_in2[0]);
        M_NOR:   nv2 = ~(dut_in2[1] | dut_in2[0]);
        default: nv2 = 1'b0;
      endcase
      if (nv2 != out2) begin
        #(nv2 ? rise2 : fall2) out2 = nv2;
      end
    end
  end

  // Inverter model, rise 5 ns / fall 7 ns
  int   kick1 = 0;
  logic nv1;
  always begin
    @(dut_in1 or kick1);
    nv1 = ~dut_in1[0];
    if (nv1 != out1) begin
      #(nv1 ? 5 : 7) out1 = nv1;
    end
  end

  // Output view of whichever instance the current vector targets
  int         cur = 2;
  logic [7:0] c_mr, c_mf;
  logic [2:0] c_rc, c_fc;
  logic [3:0] c_sc;
  logic       c_gl, c_done, c_valid, c_busy;
  always_comb begin
    if (cur == 1) begin
      c_mr = max_rise1; c_mf = max_fall1; c_rc = rise_cnt1; c_fc = fall_cnt1;
      c_sc = static_cnt1; c_gl = glitch1; c_done = done1; c_valid = valid1; c_busy = busy1;
    end else begin
      c_mr = max_rise2; c_mf = max_fall2; c_rc = rise_cnt2; c_fc = fall_cnt2;
      c_sc = static_cnt2; c_gl = glitch2; c_done = done2; c_valid = valid2; c_busy = busy2;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_mode2(input int m, input int r, input int f);
    mode2 = m; rise2 = r; fall2 = f;
    kick2++;
    repeat (20) @(negedge clk);
  endtask

  // Pulse start on the selected instance and count cycles until done
  task automatic run_and_wait(input int sel, output int cyc, output bit ok);
    cur = sel;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    check("busy_after_start", c_busy, 1);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (c_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no done within 400 cycles, expected one");
    end
  endtask

  typedef struct {
    string name;
    int sel; int mode; int rise; int fall;
    int cycles; int mr; int mf; int rc; int fc; int sc; int gl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  cyc;
    bit  ok;
    int  dones;
    bit  found;
    bit  injected;

    //             name      sel mode     r   f  cyc mr mf rc fc sc gl
    vecs[0] = '{"nand",  2, M_NAND,  10,  8,  95, 4, 3, 1, 1, 2, 0};
    vecs[1] = '{"nor",   2, M_NOR,   10, 14,  97, 4, 5, 1, 1, 2, 0};
    vecs[2] = '{"inv",   1, 0,        5,  7,  19, 2, 3, 1, 1, 0, 0};
    vecs[3] = '{"tied0", 2, M_TIED0,  0,  0, 152, 0, 0, 0, 0, 4, 0};
    vecs[4] = '{"pulse", 2, M_PULSE,  0,  0, 123, 3, 0, 1, 0, 3, 1};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_dut_in", dut_in2, 0);
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_valid", valid2, 0);
    check("rst_static", static_cnt2, 0);
    check("rst_max_rise", max_rise2, 0);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    kick1++;
    set_mode2(M_NAND, 10, 8);

    // Full-run table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].sel == 2) set_mode2(vecs[v].mode, vecs[v].rise, vecs[v].fall);
      run_and_wait(vecs[v].sel, cyc, ok);
      check({vecs[v].name, "_cycles"}, cyc, vecs[v].cycles);
      check({vecs[v].name, "_max_rise"}, c_mr, vecs[v].mr);
      check({vecs[v].name, "_max_fall"}, c_mf, vecs[v].mf);
      check({vecs[v].name, "_rise_cnt"}, c_rc, vecs[v].rc);
      check({vecs[v].name, "_fall_cnt"}, c_fc, vecs[v].fc);
      check({vecs[v].name, "_static_cnt"}, c_sc, vecs[v].sc);
      check({vecs[v].name, "_glitch"}, c_gl, vecs[v].gl);
      check({vecs[v].name, "_valid"}, c_valid, 1);
      check({vecs[v].name, "_busy_done"}, c_busy, 0);
      @(negedge clk);
      check({vecs[v].name, "_done_1cyc"}, c_done, 0);
      check({vecs[v].name, "_valid_hold"}, c_valid, 1);
    end

    // Abort in the third WAIT (vector 10 is applied at the third step)
    cur = 2;
    set_mode2(M_NAND, 10, 8);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut_in2 == 2'b10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_wait3", found, 1);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    check("abort_busy", busy2, 0);
    check("abort_dut_in", dut_in2, 0);
    check("abort_valid", valid2, 0);
    check("abort_done", done2, 0);
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done2) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_stay_idle", busy2, 0);

    // abort beats start in the same cycle
    start2 = 1'b1; abort2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; abort2 = 1'b0;
    check("abort_over_start", busy2, 0);

    // Asynchronous reset mid-run, after a fall and a static step were recorded
    set_mode2(M_NAND, 10, 8);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut_in2 == 2'b10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reach", found, 1);
    check("rstmid_pre_fall", fall_cnt2, 1);
    #0.2 rst_n = 1'b0;
    #0.5;
    check("rstmid_dut_in", dut_in2, 0);
    check("rstmid_busy", busy2, 0);
    check("rstmid_valid", valid2, 0);
    check("rstmid_max_fall", max_fall2, 0);
    check("rstmid_fall_cnt", fall_cnt2, 0);
    check("rstmid_static", static_cnt2, 0);
    #0.5 rst_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done2) dones++;
    end
    check("rstmid_no_done", dones, 0);

    // start while busy must not restart the run
    set_mode2(M_NAND, 10, 8);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; ok = 1'b0; injected = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (dut_in2 == 2'b11 && !injected) begin
        start2 = 1'b1;
        injected = 1'b1;
      end else begin
        start2 = 1'b0;
      end
      if (done2) begin
        ok = 1'b1;
        break;
      end
    end
    start2 = 1'b0;
    check("busy_start_done_seen", ok, 1);
    check("busy_start_cycles", cyc, 95);
    check("busy_start_max_rise", max_rise2, 4);
    check("busy_start_max_fall", max_fall2, 3);
    check("busy_start_static", static_cnt2, 2);
    check("busy_start_glitch", glitch2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
